ds_fifo_pkt: RTL and testbench



---
 rtl/ds_pkg.sv | 23 ++
 rtl/cm_if_lvl.sv | 19 +
 rtl/ds_if.sv | 21 ++
 rtl/ds_mem_1r1w.sv | 34 +++
 rtl/ds_fifo_pkt.sv | 223 ++++++++++++++++++++++
 tb/tb_ds_fifo_pkt.sv | 234 +++++++++++++++++++++++
 6 files changed

// File: rtl/ds_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ds_pkg
// Purpose  : Shared types and helpers for the ds_* stream blocks.
//            - t_fifo_pkt_state : packet FIFO write-side state.
//            - sclog2()         : ceil(log2(n)), never less than 1.
// Revision : 1.0 - initial release
// ============================================================================
package ds_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PKT     = 2'd1,
        DISCARD = 2'd2
    } t_fifo_pkt_state;

    // Minimum width of 1 so a 2-entry (or smaller) structure still gets a bit.
    function automatic int sclog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cm_if_lvl.sv
`default_nettype none
// ============================================================================
// Module   : cm_if_lvl
// Purpose  : Fill-level report bundle.
// Ports    : lvl, lim, lvl_gte (master -> slave), lvl_thr (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface cm_if_lvl #(
    parameter int W = 4
) ();
    logic [W-1:0] lvl;
    logic         lim;
    logic         lvl_gte;
    logic [W-1:0] lvl_thr;

    modport mst (output lvl, output lim, output lvl_gte, input lvl_thr);
    modport slv (input lvl, input lim, input lvl_gte, output lvl_thr);
endinterface
`default_nettype wire

// File: rtl/ds_if.sv
`default_nettype none
// ============================================================================
// Module   : ds_if
// Purpose  : Valid/ready stream bundle. xfer is vld & rdy.
// Ports    : data, vld (master -> slave), rdy (slave -> master), xfer (both)
// Revision : 1.0 - initial release
// ============================================================================
interface ds_if #(
    parameter type DTYPE = logic [7:0]
) ();
    DTYPE data;
    logic vld;
    logic rdy;
    logic xfer;

    assign xfer = vld & rdy;

    modport mst (output data, output vld, input rdy, input xfer);
    modport slv (input data, input vld, output rdy, input xfer);
endinterface
`default_nettype wire

// File: rtl/ds_mem_1r1w.sv
`default_nettype none
// ============================================================================
// Module   : ds_mem_1r1w
// Purpose  : Simple dual-port storage, synchronous write, asynchronous read.
//            Contents are not reset.
// Ports    : i_clk, i_we, i_waddr, i_wdata, i_raddr, o_rdata
// Revision : 1.0 - initial release
// ============================================================================
module ds_mem_1r1w
    import ds_pkg::*;
#(
    parameter type DTYPE = logic [7:0],
    parameter int  DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [sclog2(DEPTH)-1:0] i_waddr,
    input  DTYPE                     i_wdata,
    input  logic [sclog2(DEPTH)-1:0] i_raddr,
    output DTYPE                     o_rdata
);

    DTYPE mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule
`default_nettype wire

// File: rtl/ds_fifo_pkt.sv
`default_nettype none
// ============================================================================
// Module   : ds_fifo_pkt
// Purpose  : Store-and-forward packet FIFO. A frame becomes visible on the
//            read side only after its last beat is written, so read valid
//            always means at least one complete packet is held.
// Ports    : i_clk, i_rst (async, active-high)
//            if_wr / i_wr_last / i_wr_err  - write stream + sideband
//            if_wr_lvl                     - free words (incl. uncommitted)
//            if_rd / o_rd_last             - read stream, first-word-fall-through
//            if_rd_lvl                     - committed unread words
//            o_drop                        - one-cycle packet-discard pulse
// Macro    : DS_FIFO_PKT_DROP_EN - enables discard of errored / oversize
//            packets. Undefined: i_wr_err ignored, o_drop stays 0.
// Revision : 1.0 - initial release
// ============================================================================
module ds_fifo_pkt
    import ds_pkg::*;
#(
    parameter type DTYPE        = logic [7:0],
    parameter int  CAPACITY     = 16,
    parameter int  PKT_CAPACITY = 4
) (
    input  logic  i_clk,
    input  logic  i_rst,
    ds_if.slv     if_wr,
    input  logic  i_wr_last,
    input  logic  i_wr_err,
    cm_if_lvl.mst if_wr_lvl,
    ds_if.mst     if_rd,
    output logic  o_rd_last,
    cm_if_lvl.mst if_rd_lvl,
    output logic  o_drop
);

    localparam int PW = sclog2(CAPACITY);
    localparam int CW = sclog2(CAPACITY + 1);
    localparam int NW = sclog2(PKT_CAPACITY + 1);
    localparam int DW = $bits(DTYPE);

    localparam logic [PW-1:0] C_LAST    = PW'(CAPACITY - 1);
    localparam logic [CW-1:0] C_CAP     = CW'(CAPACITY);
    localparam logic [NW-1:0] C_PKT     = NW'(PKT_CAPACITY);

    t_fifo_pkt_state state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   occ_q, occ_d, cwc_q, cwc_d, seg_q, seg_d;
    logic [NW-1:0]   pcnt_q, pcnt_d;
    logic            wr_rdy_q, wr_rdy_d, rd_vld_q, rd_vld_d, drop_q, drop_d;
    logic [CW-1:0]   wr_lvl_q, wr_lvl_d, rd_lvl_q, rd_lvl_d;
    logic            wr_lim_q, wr_lim_d, rd_lim_q, rd_lim_d;
    logic            wr_gte_q, wr_gte_d, rd_gte_q, rd_gte_d;

    logic            w_disc, w_disc_d, w_store, w_err, w_ovf, w_sink_end;
    logic            w_commit, w_rollback;
    logic [DW:0]     w_rdata;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == C_LAST) ? '0 : p + PW'(1);
    endfunction

`ifdef DS_FIFO_PKT_DROP_EN
    localparam logic [CW-1:0] C_CAP_M1 = CW'(CAPACITY - 1);
    assign w_disc     = (state_q == DISCARD);
    assign w_disc_d   = (state_d == DISCARD);
    assign w_err      = w_store & i_wr_last & i_wr_err;
    // Beat that would make the open segment fill the whole memory.
    assign w_ovf      = w_store & ~i_wr_last & (seg_q == C_CAP_M1);
    assign w_sink_end = if_wr.xfer & w_disc & i_wr_last;
`else
    assign w_disc     = 1'b0;
    assign w_disc_d   = 1'b0;
    assign w_err      = i_wr_err & 1'b0;
    assign w_ovf      = 1'b0;
    assign w_sink_end = 1'b0;
`endif

    // Beats sunk in DISCARD are never written to memory.
    assign w_store    = if_wr.xfer & ~w_disc;
    assign w_commit   = w_store & i_wr_last & ~w_err;
    assign w_rollback = w_err | w_ovf;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        cmt_ptr_d = cmt_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        cwc_d     = cwc_q;
        seg_d     = seg_q;
        pcnt_d    = pcnt_q;
        state_d   = state_q;

        // Rollback drops the open segment; the current beat is not counted.
        if (w_rollback) begin
            wr_ptr_d = cmt_ptr_q;
            occ_d    = occ_q - seg_q;
            seg_d    = '0;
        end else if (w_commit) begin
            wr_ptr_d  = f_inc(wr_ptr_q);
            cmt_ptr_d = f_inc(wr_ptr_q);
            occ_d     = occ_q + CW'(1);
            cwc_d     = cwc_q + seg_q + CW'(1);
            seg_d     = '0;
            pcnt_d    = pcnt_q + NW'(1);
        end else if (w_store) begin
            wr_ptr_d = f_inc(wr_ptr_q);
            occ_d    = occ_q + CW'(1);
            seg_d    = seg_q + CW'(1);
        end

        // Read side nets against the write side, so a commit coinciding with
        // a read-last leaves pcnt unchanged.
        if (if_rd.xfer) begin
            rd_ptr_d = f_inc(rd_ptr_q);
            occ_d    = occ_d - CW'(1);
            cwc_d    = cwc_d - CW'(1);
            if (o_rd_last) begin
                pcnt_d = pcnt_d - NW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (w_store & ~i_wr_last) state_d = PKT;
            end
            PKT: begin
                if (w_ovf)                       state_d = DISCARD;
                else if (w_store & i_wr_last)    state_d = IDLE;
            end
`ifdef DS_FIFO_PKT_DROP_EN
            DISCARD: begin
                if (w_sink_end) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_rdy_d = w_disc_d | ((occ_d < C_CAP) & (pcnt_d < C_PKT));
        rd_vld_d = (pcnt_d != '0);
        drop_d   = w_err | w_sink_end;
        wr_lvl_d = C_CAP - occ_d;
        wr_lim_d = (occ_d == C_CAP);
        wr_gte_d = (wr_lvl_d >= if_wr_lvl.lvl_thr);
        rd_lvl_d = cwc_d;
        rd_lim_d = (pcnt_d == '0);
        rd_gte_d = (cwc_d >= if_rd_lvl.lvl_thr);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            cmt_ptr_q <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            cwc_q     <= '0;
            seg_q     <= '0;
            pcnt_q    <= '0;
            wr_rdy_q  <= 1'b1;
            rd_vld_q  <= 1'b0;
            drop_q    <= 1'b0;
            wr_lvl_q  <= C_CAP;
            wr_lim_q  <= 1'b0;
            wr_gte_q  <= 1'b1;
            rd_lvl_q  <= '0;
            rd_lim_q  <= 1'b1;
            rd_gte_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            cmt_ptr_q <= cmt_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            cwc_q     <= cwc_d;
            seg_q     <= seg_d;
            pcnt_q    <= pcnt_d;
            wr_rdy_q  <= wr_rdy_d;
            rd_vld_q  <= rd_vld_d;
            drop_q    <= drop_d;
            wr_lvl_q  <= wr_lvl_d;
            wr_lim_q  <= wr_lim_d;
            wr_gte_q  <= wr_gte_d;
            rd_lvl_q  <= rd_lvl_d;
            rd_lim_q  <= rd_lim_d;
            rd_gte_q  <= rd_gte_d;
        end
    end

    ds_mem_1r1w #(
        .DTYPE (logic [DW:0]),
        .DEPTH (CAPACITY)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_store),
        .i_waddr (wr_ptr_q),
        .i_wdata ({i_wr_last, if_wr.data}),
        .i_raddr (rd_ptr_q),
        .o_rdata (w_rdata)
    );

    assign if_wr.rdy         = wr_rdy_q;
    assign if_rd.vld         = rd_vld_q;
    assign if_rd.data        = DTYPE'(w_rdata[DW-1:0]);
    assign o_rd_last         = w_rdata[DW];
    assign o_drop            = drop_q;
    assign if_wr_lvl.lvl     = wr_lvl_q;
    assign if_wr_lvl.lim     = wr_lim_q;
    assign if_wr_lvl.lvl_gte = wr_gte_q;
    assign if_rd_lvl.lvl     = rd_lvl_q;
    assign if_rd_lvl.lim     = rd_lim_q;
    // A zero threshold is always met, including straight out of reset.
    assign if_rd_lvl.lvl_gte = rd_gte_q | (if_rd_lvl.lvl_thr == '0);

`ifndef DS_FIFO_PKT_DROP_EN
    // Without discard support a packet that fills memory can never commit.
    a_no_oversize: assert property (@(posedge i_clk) disable iff (i_rst)
        !((seg_q == C_CAP) && (pcnt_q == '0)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_ds_fifo_pkt.sv
`default_nettype none
// ============================================================================
// Module   : tb_ds_fifo_pkt
// Purpose  : Directed self-checking bench for ds_fifo_pkt
//            (CAPACITY=8, PKT_CAPACITY=2, wr thr=4, rd thr=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ds_fifo_pkt;

    localparam int CAP  = 8;
    localparam int PKTC = 2;
    localparam int LW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_last = 1'b0;
    logic wr_err  = 1'b0;
    logic rd_last;
    logic drop;
    int   n_chk  = 0;
    int   n_fail = 0;

    ds_if #(.DTYPE(logic [7:0])) wr_if ();
    ds_if #(.DTYPE(logic [7:0])) rd_if ();
    cm_if_lvl #(.W(LW)) wr_lvl ();
    cm_if_lvl #(.W(LW)) rd_lvl ();

    ds_fifo_pkt #(
        .DTYPE        (logic [7:0]),
        .CAPACITY     (CAP),
        .PKT_CAPACITY (PKTC)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .if_wr     (wr_if),
        .i_wr_last (wr_last),
        .i_wr_err  (wr_err),
        .if_wr_lvl (wr_lvl),
        .if_rd     (rd_if),
        .o_rd_last (rd_last),
        .if_rd_lvl (rd_lvl),
        .o_drop    (drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_wr_rdy"}, wr_if.rdy, 1);
        chk({tag, "_rd_vld"}, rd_if.vld, 0);
        chk({tag, "_drop"},   drop, 0);
        chk({tag, "_wr_lvl"}, wr_lvl.lvl, CAP);
        chk({tag, "_wr_lim"}, wr_lvl.lim, 0);
        chk({tag, "_wr_gte"}, wr_lvl.lvl_gte, 1);
        chk({tag, "_rd_lvl"}, rd_lvl.lvl, 0);
        chk({tag, "_rd_lim"}, rd_lvl.lim, 1);
        chk({tag, "_rd_gte"}, rd_lvl.lvl_gte, 0);
    endtask

    task automatic wr_beat(input logic [7:0] d, input logic last, input logic err);
        wr_if.vld  = 1'b1;
        wr_if.data = d;
        wr_last    = last;
        wr_err     = err;
        chk("wr_rdy_before_beat", wr_if.rdy, 1);
        step();
        wr_if.vld  = 1'b0;
        wr_last    = 1'b0;
        wr_err     = 1'b0;
    endtask

    task automatic rd_beat(input logic [7:0] d, input logic last);
        chk("rd_vld", rd_if.vld, 1);
        chk("rd_data", rd_if.data, d);
        chk("rd_last", rd_last, last);
        rd_if.rdy = 1'b1;
        step();
        rd_if.rdy = 1'b0;
    endtask

    initial begin
        wr_if.vld      = 1'b0;
        wr_if.data     = '0;
        rd_if.rdy      = 1'b0;
        wr_lvl.lvl_thr = 4'd4;
        rd_lvl.lvl_thr = 4'd2;
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst");
        rst = 1'b0;
        step();

        // 3-beat packet, visible only after the last beat
        wr_beat(8'hA0, 1'b0, 1'b0);
        chk("t1_wr_lvl_a0", wr_lvl.lvl, 7);
        chk("t1_vld_partial", rd_if.vld, 0);
        wr_beat(8'hA1, 1'b0, 1'b0);
        chk("t1_vld_partial2", rd_if.vld, 0);
        wr_beat(8'hA2, 1'b1, 1'b0);
        chk("t1_vld_commit", rd_if.vld, 1);
        chk("t1_rd_lvl", rd_lvl.lvl, 3);
        chk("t1_rd_lim", rd_lvl.lim, 0);
        chk("t1_rd_gte", rd_lvl.lvl_gte, 1);
        chk("t1_wr_lvl", wr_lvl.lvl, 5);
        rd_beat(8'hA0, 1'b0);
        rd_beat(8'hA1, 1'b0);
        rd_beat(8'hA2, 1'b1);
        chk("t1_vld_empty", rd_if.vld, 0);
        chk("t1_rd_lim_empty", rd_lvl.lim, 1);
        chk("t1_rd_lvl_empty", rd_lvl.lvl, 0);
        chk("t1_wr_lvl_empty", wr_lvl.lvl, 8);

        // packet-count limit
        wr_beat(8'hB0, 1'b1, 1'b0);
        chk("t2_rdy_one", wr_if.rdy, 1);
        wr_beat(8'hB1, 1'b1, 1'b0);
        chk("t2_rdy_full", wr_if.rdy, 0);
        wr_if.vld  = 1'b1;
        wr_if.data = 8'hC0;
        wr_last    = 1'b1;
        step();
        chk("t2_rdy_held", wr_if.rdy, 0);
        chk("t2_rd_lvl_held", rd_lvl.lvl, 2);
        chk("t2_rd_b0", rd_if.data, 8'hB0);
        rd_if.rdy = 1'b1;
        step();
        rd_if.rdy = 1'b0;
        chk("t2_rdy_back", wr_if.rdy, 1);
        chk("t2_rd_b1", rd_if.data, 8'hB1);
        step();
        wr_if.vld = 1'b0;
        wr_last   = 1'b0;
        chk("t2_rdy_full2", wr_if.rdy, 0);
        chk("t2_rd_lvl2", rd_lvl.lvl, 2);
        rd_beat(8'hB1, 1'b1);
        rd_beat(8'hC0, 1'b1);
        chk("t2_vld_empty", rd_if.vld, 0);

        // commit and read-last in the same cycle
        wr_beat(8'hD0, 1'b0, 1'b0);
        wr_beat(8'hD1, 1'b0, 1'b0);
        wr_beat(8'hD2, 1'b1, 1'b0);
        begin
            int exp_wl [6] = '{4, 3, 2, 2, 2, 2};
            int exp_rl [6] = '{3, 3, 3, 2, 1, 6};
            for (int c = 0; c < 6; c++) begin
                wr_if.vld  = 1'b1;
                wr_if.data = 8'(8'hE0 + c);
                wr_last    = (c == 5);
                chk("t3_wr_rdy", wr_if.rdy, 1);
                if (c >= 3) begin
                    chk("t3_rd_data", rd_if.data, 8'hD0 + c - 3);
                    chk("t3_rd_last", rd_last, (c == 5) ? 1 : 0);
                    rd_if.rdy = 1'b1;
                end
                step();
                chk("t3_wr_lvl", wr_lvl.lvl, exp_wl[c]);
                chk("t3_rd_lvl", rd_lvl.lvl, exp_rl[c]);
                chk("t3_rd_vld", rd_if.vld, 1);
            end
        end
        wr_if.vld = 1'b0;
        wr_last   = 1'b0;
        rd_if.rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rd_beat(8'(8'hE0 + i), (i == 5));
        end
        chk("t3_vld_empty", rd_if.vld, 0);
        chk("t3_wr_lvl_empty", wr_lvl.lvl, 8);

`ifdef DS_FIFO_PKT_DROP_EN
        // errored packet
        wr_beat(8'h40, 1'b0, 1'b0);
        wr_beat(8'h41, 1'b0, 1'b0);
        wr_beat(8'h42, 1'b0, 1'b0);
        wr_beat(8'h43, 1'b1, 1'b1);
        chk("d1_drop", drop, 1);
        chk("d1_wr_lvl", wr_lvl.lvl, 8);
        chk("d1_vld", rd_if.vld, 0);
        step();
        chk("d1_drop_end", drop, 0);

        // oversize packet
        for (int i = 0; i < 10; i++) begin
            wr_beat(8'(8'h50 + i), (i == 9), 1'b0);
            if (i == 7) chk("d2_wr_lvl_rollback", wr_lvl.lvl, 8);
            if (i < 9)  chk("d2_no_drop", drop, 0);
        end
        chk("d2_drop", drop, 1);
        chk("d2_vld", rd_if.vld, 0);
        wr_beat(8'h60, 1'b0, 1'b0);
        wr_beat(8'h61, 1'b1, 1'b0);
        rd_beat(8'h60, 1'b0);
        rd_beat(8'h61, 1'b1);
`endif

        // reset mid-packet with one committed packet
        wr_beat(8'hF0, 1'b1, 1'b0);
        wr_beat(8'hF1, 1'b0, 1'b0);
        wr_beat(8'hF2, 1'b0, 1'b0);
        chk("t4_vld_before", rd_if.vld, 1);
        rst = 1'b1;
        step();
        check_reset("t4");
        rst = 1'b0;
        step();
        wr_beat(8'h77, 1'b1, 1'b0);
        rd_beat(8'h77, 1'b1);
        chk("t4_vld_after", rd_if.vld, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, checks=%0d", n_chk);
        $fatal(1);
    end

endmodule
`default_nettype wire
